// File: rtl/recv_pkg.sv
// Shared types for the recv link receiver: state encoding, bus widths, debug view.
// The optional checksum state is only reachable when RECV_CHKSUM_EN is defined.
package recv_pkg;

  localparam int RECV_ID_W  = 32;
  localparam int RECV_LEN_W = 8;

  typedef logic [RECV_ID_W-1:0]  recv_id_t;
  typedef logic [RECV_LEN_W-1:0] recv_len_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_CHK   = 3'd6
  } recv_state_t;

  typedef struct packed {
    recv_state_t state;
    logic [7:0]  xor_acc;
  } recv_dbg_t;

  // States in which the link may hand us a byte (and the idle timeout runs).
  function automatic logic rx_state(input recv_state_t s);
    return (s == S_HDR) || (s == S_LEN) || (s == S_DATA) || (s == S_CHK);
  endfunction

endpackage

// File: rtl/recv_pack.sv
// Byte packer for recv: little-endian word shifter, 2-bit byte counter and
// running XOR of every frame byte.
module recv_pack
  import recv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe,
  input  logic        shift,
  input  logic        clear,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full,
  output logic [7:0]  xor_acc
);

  logic [1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word    <= '0;
      cnt     <= '0;
      xor_acc <= '0;
    end else if (clear) begin
      word    <= '0;
      cnt     <= '0;
      xor_acc <= '0;
    end else begin
      if (strobe) xor_acc <= xor_acc ^ data;
      // Shifting in from the top leaves the first byte in [7:0] after four.
      if (shift) begin
        word <= {data, word[31:8]};
        cnt  <= cnt + 2'd1;
      end
    end
  end

  assign word_full = shift && (cnt == 2'd3);

endmodule

// File: rtl/recv.sv
// Frame receiver: header ID, length, payload words written to memory.
// Optional trailing checksum byte is enabled with RECV_CHKSUM_EN.
module recv
  import recv_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        recv_start_i,
  input  logic [31:0] base_addr_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_hold_i,
  output recv_id_t    ID_o,
  output recv_len_t   len_o,
  output logic        busy_o,
  output logic        ready_o,
  output logic        err_o,
  output recv_dbg_t   dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);

`ifdef RECV_CHKSUM_EN
  localparam recv_state_t S_END = S_CHK;
`else
  localparam recv_state_t S_END = S_DONE;
`endif

  recv_state_t state, state_nxt;
  logic [31:0] base;
  logic [7:0]  n_words;
  logic [7:0]  word_idx;
  logic [TW-1:0] tmo_cnt;
  logic        xfer, start_acc, tmo_hit, err_set, wr_done, too_long;
  logic [31:0] pack_word;
  logic        word_full;
  logic [7:0]  xor_acc;

  // Link handshake: a byte moves on a cycle where rx_valid_i and rx_ready_o
  // are both high; rx_ready_o depends only on state, never on rx_valid_i.
  assign rx_ready_o = rx_state(state);
  assign xfer       = rx_valid_i && rx_ready_o;
  assign start_acc  = (state == S_IDLE) && recv_start_i;
  assign too_long   = {24'd0, rx_data_i} > 32'(MAX_WORDS);

  recv_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .strobe    (xfer),
    .shift     (xfer && ((state == S_HDR) || (state == S_DATA))),
    .clear     (start_acc),
    .data      (rx_data_i),
    .word      (pack_word),
    .word_full (word_full),
    .xor_acc   (xor_acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      base     <= '0;
      ID_o     <= '0;
      len_o    <= '0;
      err_o    <= 1'b0;
      n_words  <= '0;
      word_idx <= '0;
      tmo_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        base     <= base_addr_i;
        ID_o     <= '0;
        len_o    <= '0;
        err_o    <= 1'b0;
        n_words  <= '0;
        word_idx <= '0;
        tmo_cnt  <= '0;
      end
      if ((state == S_HDR) && xfer) ID_o <= {rx_data_i, ID_o[31:8]};
      if ((state == S_LEN) && xfer) n_words <= rx_data_i;
      if (rx_state(state)) tmo_cnt <= xfer ? '0 : tmo_cnt + TW'(1);
      if (wr_done) begin
        word_idx <= word_idx + 8'd1;
        len_o    <= len_o + 8'd1;
      end
      if (err_set) err_o <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    wr_done   = 1'b0;
    // The DONE cycle itself is the TIMEOUT-th cycle without a transfer.
    tmo_hit   = rx_state(state) && !xfer && (tmo_cnt == TW'(TIMEOUT - 2));
    case (state)
      S_IDLE: if (recv_start_i) state_nxt = S_HDR;
      S_HDR: begin
        if (tmo_hit) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end else if (word_full) begin
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (tmo_hit) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end else if (xfer) begin
          if (rx_data_i == 8'd0) begin
            state_nxt = S_END;
          end else if (too_long) begin
            state_nxt = S_DONE;
            err_set   = 1'b1;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tmo_hit) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end else if (word_full) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!mem_hold_i) begin
          wr_done   = 1'b1;
          state_nxt = ((word_idx + 8'd1) == n_words) ? S_END : S_DATA;
        end
      end
`ifdef RECV_CHKSUM_EN
      S_CHK: begin
        if (tmo_hit) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end else if (xfer) begin
          state_nxt = S_DONE;
          if (rx_data_i != xor_acc) err_set = 1'b1;
        end
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_req_o   = (state == S_WRITE);
  assign mem_we_o    = mem_req_o;
  assign mem_waddr_o = mem_req_o ? ((base & ~32'h3) + {22'd0, word_idx, 2'b00}) : '0;
  assign mem_wdata_o = mem_req_o ? pack_word : '0;
  assign busy_o      = rx_state(state) || (state == S_WRITE);
  assign ready_o     = (state == S_DONE);
  assign dbg         = '{state: state, xor_acc: xor_acc};

endmodule

// File: tb/tb_recv.sv
// Directed bench for recv: frames, bus hold, length error, timeout, reset
// during a write, address wrap and (with RECV_CHKSUM_EN) the checksum byte.
module tb_recv;
  import recv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        recv_start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_ready_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_waddr_o, mem_wdata_o;
  logic        mem_hold_i = 1'b0;
  logic [31:0] ID_o;
  logic [7:0]  len_o;
  logic        busy_o, ready_o, err_o;
  recv_dbg_t   dbg;

  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  fq[$];
  logic [7:0]  chk_acc;

  always #5 clk = ~clk;

  recv #(.MAX_WORDS(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .recv_start_i(recv_start_i), .base_addr_i(base_addr_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o), .mem_hold_i(mem_hold_i), .ID_o(ID_o), .len_o(len_o),
    .busy_o(busy_o), .ready_o(ready_o), .err_o(err_o), .dbg(dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: a write completes on a cycle with mem_req_o and no hold.
  always begin
    @(negedge clk);
    #1;
    if (rst && mem_req_o && !mem_hold_i) begin
      n_total++;
      assert (exp_q.size() > 0) else begin
        n_bad++;
        $error("FAIL wr_unexpected observed=%h@%h expected=none", mem_wdata_o, mem_waddr_o);
      end
      if (exp_q.size() > 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_waddr_o, e[63:32]);
        chk("wr_data", mem_wdata_o, e[31:0]);
        chk("wr_we", {31'd0, mem_we_o}, 32'd1);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    chk_acc = chk_acc ^ b;
  endtask

  task automatic push_hdr(input logic [31:0] id, input logic [7:0] n);
    chk_acc = 8'h00;
    push_byte(id[7:0]);
    push_byte(id[15:8]);
    push_byte(id[23:16]);
    push_byte(id[31:24]);
    push_byte(n);
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] addr);
    push_byte(w[7:0]);
    push_byte(w[15:8]);
    push_byte(w[23:16]);
    push_byte(w[31:24]);
    exp_q.push_back({addr, w});
  endtask

  task automatic push_chk();
`ifdef RECV_CHKSUM_EN
    logic [7:0] c;
    c = chk_acc;
    fq.push_back(c);
`endif
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_ready_timeout", {31'd0, rx_ready_o}, 32'd1);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_fq();
    while (fq.size() > 0) send_byte(fq.pop_front());
  endtask

  task automatic start(input logic [31:0] base);
    @(negedge clk);
    recv_start_i = 1'b1;
    base_addr_i  = base;
    @(negedge clk);
    recv_start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] id, input logic [7:0] len,
                           input logic err);
    int k;
    k = 0;
    while (!ready_o && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    chk({tag, "_id"}, ID_o, id);
    chk({tag, "_len"}, {24'd0, len_o}, {24'd0, len});
    chk({tag, "_err"}, {31'd0, err_o}, {31'd0, err});
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, ready_o}, 32'd0);
    chk({tag, "_err_held"}, {31'd0, err_o}, {31'd0, err});
  endtask

  task automatic hold_ctrl();
    int n;
    logic [31:0] a, d;
    n = 0;
    while (!mem_req_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    a = mem_waddr_o;
    d = mem_wdata_o;
    chk("t2_first_addr", a, 32'h1000_0100);
    chk("t2_first_data", d, 32'h0000_0001);
    for (int i = 0; i < 6; i++) begin
      chk("t2_hold_req", {31'd0, mem_req_o}, 32'd1);
      chk("t2_hold_addr", mem_waddr_o, a);
      chk("t2_hold_data", mem_wdata_o, d);
      chk("t2_hold_rxrdy", {31'd0, rx_ready_o}, 32'd0);
      if (i < 5) @(negedge clk);
    end
    mem_hold_i = 1'b0;
  endtask

  task automatic frame_basic();
    start(32'h1000_0100);
    chk("hdr_busy", {31'd0, busy_o}, 32'd1);
    chk("hdr_rxrdy", {31'd0, rx_ready_o}, 32'd1);
    push_hdr(32'h1234_5678, 8'd2);
    push_word(32'h0000_0001, 32'h1000_0100);
    push_word(32'hCCDD_EEFF, 32'h1000_0104);
    push_chk();
  endtask

  initial begin
    #3;
    chk("rst_rxrdy", {31'd0, rx_ready_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_waddr", mem_waddr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_id", ID_o, 32'd0);
    chk("rst_len", {24'd0, len_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy_o}, 32'd0);

    // 1: two-word frame, no hold
    frame_basic();
    send_fq();
    wait_done("t1", 32'h1234_5678, 8'd2, 1'b0);

    // 2: same frame, first write held for 5 cycles
    frame_basic();
    mem_hold_i = 1'b1;
    fork
      send_fq();
      hold_ctrl();
    join
    wait_done("t2", 32'h1234_5678, 8'd2, 1'b0);

    // 3: length above MAX_WORDS
    start(32'h0000_4000);
    push_hdr(32'hA5A5_A5A5, 8'd65);
    send_fq();
    wait_done("t3", 32'hA5A5_A5A5, 8'd0, 1'b1);

    // 4: link stalls after six payload bytes
    start(32'h3000_0000);
    push_hdr(32'hCAFE_0004, 8'd2);
    push_word(32'h4433_2211, 32'h3000_0000);
    push_byte(8'h55);
    push_byte(8'h66);
    send_fq();
    begin
      int k;
      k = 1;
      while (!ready_o && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("t4_idle_cycles", k, 16);
    end
    wait_done("t4", 32'hCAFE_0004, 8'd1, 1'b1);

    // 5: reset while a write is held
    mem_hold_i = 1'b1;
    start(32'h2000_0000);
    push_hdr(32'h0BAD_F00D, 8'd1);
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    send_fq();
    chk("t5_req_pre", {31'd0, mem_req_o}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_req", {31'd0, mem_req_o}, 32'd0);
    chk("t5_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_ready", {31'd0, ready_o}, 32'd0);
    chk("t5_rxrdy", {31'd0, rx_ready_o}, 32'd0);
    chk("t5_id", ID_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_hold_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t5_idle_busy", {31'd0, busy_o}, 32'd0);
      chk("t5_idle_req", {31'd0, mem_req_o}, 32'd0);
    end
    frame_basic();
    send_fq();
    wait_done("t5_after", 32'h1234_5678, 8'd2, 1'b0);

    // 7: unaligned base near the top of memory, address wraps
    start(32'hFFFF_FFFF);
    push_hdr(32'h0000_0077, 8'd2);
    push_word(32'hDEAD_BEEF, 32'hFFFF_FFFC);
    push_word(32'h0102_0304, 32'h0000_0000);
    push_chk();
    send_fq();
    wait_done("t7", 32'h0000_0077, 8'd2, 1'b0);

`ifdef RECV_CHKSUM_EN
    // 6: checksum good then bad, empty payload
    start(32'h0000_0000);
    push_hdr(32'h0000_0001, 8'd0);
    fq.push_back(8'h01);
    send_fq();
    wait_done("t6_good", 32'h0000_0001, 8'd0, 1'b0);
    start(32'h0000_0000);
    push_hdr(32'h0000_0001, 8'd0);
    fq.push_back(8'h00);
    send_fq();
    wait_done("t6_bad", 32'h0000_0001, 8'd0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/recv.md
Name: recv

Overview:
- Receive-side counterpart of the core's send unit.
- Accepts a framed byte stream from an external link, packs the bytes into 32-bit words and writes them to memory through the EX-side bus request path. Once a frame has been fully written, it reports the frame ID to ex.
- Sits beside div/send in tinyriscv. Started by ex; its memory port is muxed onto rib_ex_* by the core top.

Parameters:
- MAX_WORDS, 64, maximum payload length in words; a larger length field is an error.
- TIMEOUT, 1024, idle cycles allowed between accepted bytes before the frame is aborted.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- recv_start_i  in  1  single-cycle start pulse from ex
- base_addr_i  in  32  destination word address, sampled with start; bits[1:0] are ignored
- rx_valid_i  in  1  link byte valid
- rx_data_i  in  8  link byte
- rx_ready_o  out  1  recv can take a byte; a byte transfers when valid&ready
- mem_req_o  out  1  bus request
- mem_we_o  out  1  write enable (always equal to mem_req_o)
- mem_waddr_o  out  32  write address
- mem_wdata_o  out  32  write data
- mem_hold_i  in  1  bus not granted; the current write must be held
- ID_o  out  32  frame header ID
- len_o  out  8  number of words written
- busy_o  out  1  frame in progress
- ready_o  out  1  one-cycle completion pulse
- err_o  out  1  last frame aborted; valid together with ready_o, held until next start

Behaviour:
- Reset (async, rst=0): state goes to IDLE; every output is 0; counters cleared.
- Frame format:
  - 4 header bytes, little-endian: the first byte goes to ID[7:0].
  - 1 length byte N.
  - N×4 payload bytes, little-endian per word.
  - [checksum byte, only with the optional feature].
- States: IDLE, HDR, LEN, DATA, WRITE, DONE.
- IDLE:
  - rx_ready_o=0.
  - On recv_start_i: latch base_addr_i; clear ID_o, len_o, err_o; go to HDR.
  - recv_start_i in any other state is ignored.
- HDR:
  - rx_ready_o=1.
  - Shift bytes into ID_o; after the 4th byte go to LEN.
- LEN:
  - rx_ready_o=1; accept one byte N.
  - N=0: go to DONE (or CHK).
  - N>MAX_WORDS: go to DONE with err_o=1; no writes are issued.
  - Otherwise: go to DATA.
- DATA:
  - rx_ready_o=1; pack bytes into a 32-bit word.
  - After the 4th byte go to WRITE. No byte is accepted on that transition cycle.
- WRITE:
  - rx_ready_o=0; mem_req_o=mem_we_o=1.
  - mem_waddr_o = base + 4×word_idx; mem_wdata_o = packed word.
  - Hold all outputs while mem_hold_i=1.
  - In the first cycle with mem_hold_i=0 the write completes: word_idx++, len_o++.
  - Then go to DATA, or to DONE (CHK) if word_idx==N.
- DONE:
  - ready_o=1 for exactly one cycle; busy_o=0; then go to IDLE.
- busy_o = 1 in HDR, LEN, DATA, WRITE (and CHK).
- Timeout:
  - In HDR, LEN, DATA (and CHK) a counter increments on every cycle without a byte transfer and clears on each transfer.
  - When it reaches TIMEOUT: go to DONE, err_o=1.
  - Words already written stay written; len_o reflects them.
  - The counter is frozen in WRITE.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no error.
- Reset mid-frame: an in-flight WRITE is dropped (mem_req_o falls asynchronously); no partial state survives.

Optional Feature:
- Macro: RECV_CHKSUM_EN.
- Defined:
  - Adds state CHK after the last payload word (or after LEN when N=0); rx_ready_o=1 there.
  - One byte is accepted and compared with the XOR of all preceding frame bytes (header, length, payload).
  - On mismatch err_o=1; DONE follows either way.
  - Payload is already written by then; err_o only flags it.
- Undefined: no CHK state; the frame ends after the last write. Timeout behaviour is unchanged.

Decomposition:
- defines.v (shared include):
  - recv state encodings
  - RecvIdBus (31:0)
  - RecvLenBus (7:0)
- Sub-module recv_pack:
  - Holds the byte shifter, 2-bit byte counter and running XOR.
  - Inputs: byte strobe, byte, clear.
  - Outputs: word, word_full, xor_acc.
- recv owns the FSM, timeout counter, address/length counters and bus handshake.

Test Plan:
1. start, base=0x1000_0100; bytes 78 56 34 12, 02, 01 00 00 00, FF EE DD CC, no hold → writes 0x00000001@0x10000100 and 0xCCDDEEFF@0x10000104; ID_o=0x12345678, len_o=2, single ready_o pulse, err_o=0.
2. Same frame with mem_hold_i=1 for 5 cycles on the first write → address and data stable for 6 cycles; rx_ready_o=0 throughout; exactly one write per word.
3. Length byte 65 (MAX_WORDS=64) → no mem_req_o; ready_o pulse with err_o=1, len_o=0.
4. Stop rx_valid_i after 6 payload bytes, TIMEOUT=16 → ready_o with err_o=1 on the 16th idle cycle; len_o=1.
5. Drop rst low during WRITE → mem_req_o, busy_o, ready_o go to 0 without a clock edge; after release recv stays IDLE and a new start completes normally.
6. RECV_CHKSUM_EN: frame ID=0x00000001, N=0, checksum 0x01 → err_o=0; checksum 0x00 → err_o=1.
